// File: rtl/demux4_if.sv
// Producer-side and consumer-side handshake bundle for the four-way routing buffer.
// The slave view belongs to demux4. The master view drives it from the producer and consumer side.
interface demux4_if #(
  parameter int WIDTH = 28
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out2_valid;
  logic             out2_ready;
  logic [WIDTH-1:0] out2_data;
  logic             out3_valid;
  logic             out3_ready;
  logic [WIDTH-1:0] out3_data;

  logic             busy;

  modport slave (
    input  in_valid, in_data, in_sel,
    input  out0_ready, out1_ready, out2_ready, out3_ready,
    output in_ready,
    output out0_valid, out0_data, out1_valid, out1_data,
    output out2_valid, out2_data, out3_valid, out3_data,
    output busy
  );

  modport master (
    output in_valid, in_data, in_sel,
    output out0_ready, out1_ready, out2_ready, out3_ready,
    input  in_ready,
    input  out0_valid, out0_data, out1_valid, out1_data,
    input  out2_valid, out2_data, out3_valid, out3_data,
    input  busy
  );
endinterface

// File: rtl/demux4.sv
// Four-way routing buffer: one input word per cycle is steered by in_sel into one of four
// independent DEPTH-entry FIFOs, each drained by its own valid/ready consumer.
module demux4 #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  demux4_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]       full;
  logic [3:0]       valid;
  logic [3:0]       ready;
  logic [WIDTH-1:0] head [4];
  logic             in_ready;
  logic             accept;

  // in_ready looks only at the selected channel's registered occupancy, never at consumer ready.
  assign in_ready = !full[bus.in_sel];
  assign accept   = bus.in_valid && in_ready;

  assign ready = {bus.out3_ready, bus.out2_ready, bus.out1_ready, bus.out0_ready};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      logic [WIDTH-1:0] mem [DEPTH];
      logic [AW-1:0]    wr_ptr_reg;
      logic [AW-1:0]    rd_ptr_reg;
      logic [CW-1:0]    count_reg;
      logic             push;
      logic             pop;

      assign full[gi]  = (count_reg == CW'(DEPTH));
      assign valid[gi] = (count_reg != '0);
      assign push      = accept && (bus.in_sel == 2'(gi));
      assign pop       = valid[gi] && ready[gi];
      assign head[gi]  = valid[gi] ? mem[rd_ptr_reg] : '0;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
          end
        end else begin
          if (push) begin
            mem[wr_ptr_reg] <= bus.in_data;
            wr_ptr_reg      <= wr_ptr_reg + AW'(1);
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
          end
          case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  assign bus.in_ready   = in_ready;
  assign bus.busy       = |valid;

  assign bus.out0_valid = valid[0];
  assign bus.out1_valid = valid[1];
  assign bus.out2_valid = valid[2];
  assign bus.out3_valid = valid[3];
  assign bus.out0_data  = head[0];
  assign bus.out1_data  = head[1];
  assign bus.out2_data  = head[2];
  assign bus.out3_data  = head[3];
endmodule

// File: tb/tb_demux4.sv
// Directed bench for demux4: routing, backpressure, drain order, concurrent push/pop,
// pointer wrap and asynchronous mid-operation reset.
module tb_demux4;
  localparam int WIDTH = 28;
  localparam int DEPTH = 2;

  logic clk;
  logic reset;
  int   tests;
  int   failed;

  demux4_if #(.WIDTH(WIDTH)) bus ();

  demux4 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [3:0]       ordy;
  logic             ov [4];
  logic [WIDTH-1:0] od [4];

  assign bus.out0_ready = ordy[0];
  assign bus.out1_ready = ordy[1];
  assign bus.out2_ready = ordy[2];
  assign bus.out3_ready = ordy[3];
  assign ov[0] = bus.out0_valid;
  assign ov[1] = bus.out1_valid;
  assign ov[2] = bus.out2_valid;
  assign ov[3] = bus.out3_valid;
  assign od[0] = bus.out0_data;
  assign od[1] = bus.out1_data;
  assign od[2] = bus.out2_data;
  assign od[3] = bus.out3_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sel   = 2'b00;
    ordy         = 4'b0000;
  endtask

  task automatic push(input logic [1:0] sel, input logic [WIDTH-1:0] data);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = data;
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (ov[k] !== 1'b0 || od[k] !== '0) begin
        failed++;
        $display("FAIL reset_out%0d: valid=%b data=%h, want valid=0 data=0", k, ov[k], od[k]);
      end
    end
    tests++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_status: busy=%b in_ready=%b, want busy=0 in_ready=1", bus.busy, bus.in_ready);
    end
    reset = 1'b0;
    cycle();
    $display("[TB] test_reset done");
  endtask

  task automatic test_routing();
    logic [WIDTH-1:0] exp [4];
    exp[0] = 28'h00FFFFF;
    exp[1] = 28'h0000555;
    exp[2] = 28'h0000810;
    exp[3] = 28'h00CCCCC;
    idle();
    push(2'b01, 28'h0000555);
    push(2'b00, 28'h00FFFFF);
    push(2'b11, 28'h00CCCCC);
    push(2'b10, 28'h0000810);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (ov[k] !== 1'b1 || od[k] !== exp[k]) begin
        failed++;
        $display("FAIL routing_out%0d: valid=%b data=%h, want valid=1 data=%h", k, ov[k], od[k], exp[k]);
      end
    end
    tests++;
    if (bus.busy !== 1'b1) begin
      failed++;
      $display("FAIL routing_busy: got %b want 1", bus.busy);
    end
    $display("[TB] test_routing done");
  endtask

  task automatic test_fill_backpressure();
    pulse_reset();
    idle();
    push(2'b10, 28'h1);
    push(2'b10, 28'h2);
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'b10;
    bus.in_data  = 28'h3;
    #1;
    tests++;
    if (bus.in_ready !== 1'b0) begin
      failed++;
      $display("FAIL full_in_ready: got %b want 0", bus.in_ready);
    end
    bus.in_sel = 2'b00;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      failed++;
      $display("FAIL switch_in_ready: got %b want 1", bus.in_ready);
    end
    cycle();
    bus.in_valid = 1'b0;
    tests++;
    if (ov[0] !== 1'b1 || od[0] !== 28'h3 || od[2] !== 28'h1) begin
      failed++;
      $display("FAIL switch_landing: out0 valid=%b data=%h out2 data=%h, want 1/3 and 1", ov[0], od[0], od[2]);
    end
    $display("[TB] test_fill_backpressure done");
  endtask

  task automatic test_drain();
    logic [WIDTH-1:0] exp [3];
    logic             expv [3];
    exp[0] = 28'h1; exp[1] = 28'h2; exp[2] = 28'h0;
    expv[0] = 1'b1; expv[1] = 1'b1; expv[2] = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sel   = 2'b10;
    ordy[2]      = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b0) begin
      failed++;
      $display("FAIL full_pop_in_ready: got %b want 0", bus.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (ov[2] !== expv[i] || od[2] !== exp[i]) begin
        failed++;
        $display("FAIL drain_step%0d: valid=%b data=%h, want valid=%b data=%h", i, ov[2], od[2], expv[i], exp[i]);
      end
      cycle();
    end
    ordy[2] = 1'b0;
    $display("[TB] test_drain done");
  endtask

  task automatic test_simultaneous();
    logic [WIDTH-1:0] stream [4];
    stream[0] = 28'hB; stream[1] = 28'hC; stream[2] = 28'hD; stream[3] = 28'hE;
    pulse_reset();
    idle();
    push(2'b01, 28'hA);
    ordy[1]      = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'b01;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = stream[i];
      #1;
      tests++;
      if (bus.in_ready !== 1'b1) begin
        failed++;
        $display("FAIL stream_ready%0d: got %b want 1", i, bus.in_ready);
      end
      cycle();
      tests++;
      if (ov[1] !== 1'b1 || od[1] !== stream[i]) begin
        failed++;
        $display("FAIL stream_word%0d: valid=%b data=%h, want valid=1 data=%h", i, ov[1], od[1], stream[i]);
      end
    end
    bus.in_valid = 1'b0;
    cycle();
    tests++;
    if (ov[1] !== 1'b0 || od[1] !== '0) begin
      failed++;
      $display("FAIL stream_empty: valid=%b data=%h, want 0/0", ov[1], od[1]);
    end
    ordy[1] = 1'b0;
    $display("[TB] test_simultaneous done");
  endtask

  task automatic test_wrap();
    int   sent;
    int   recv;
    int   cnt;
    logic do_push;
    logic do_pop;
    sent = 0; recv = 0; cnt = 0;
    pulse_reset();
    idle();
    bus.in_sel = 2'b11;
    for (int cyc = 0; cyc < 200 && recv < 10; cyc++) begin
      ordy[3]      = 1'($urandom_range(0, 1));
      bus.in_valid = (sent < 10);
      bus.in_data  = WIDTH'(32'h10 + sent);
      #1;
      tests++;
      if (bus.in_ready !== (cnt != DEPTH) || ov[3] !== (cnt != 0)) begin
        failed++;
        $display("FAIL wrap_flags cyc%0d: in_ready=%b valid=%b, want %b/%b", cyc, bus.in_ready, ov[3], cnt != DEPTH, cnt != 0);
      end
      do_push = bus.in_valid && (cnt != DEPTH);
      do_pop  = ordy[3] && (cnt != 0);
      if (do_pop) begin
        tests++;
        if (od[3] !== WIDTH'(32'h10 + recv)) begin
          failed++;
          $display("FAIL wrap_word%0d: got %h want %h", recv, od[3], 32'h10 + recv);
        end
        recv++;
      end
      cycle();
      if (do_push) sent++;
      cnt = cnt + int'(do_push) - int'(do_pop);
    end
    tests++;
    if (recv != 10 || ov[3] !== 1'b0) begin
      failed++;
      $display("FAIL wrap_complete: received %0d valid=%b, want 10 and 0", recv, ov[3]);
    end
    idle();
    $display("[TB] test_wrap done");
  endtask

  task automatic test_mid_reset();
    pulse_reset();
    idle();
    for (int i = 0; i < 8; i++) push(2'(i % 4), WIDTH'(32'h100 + i));
    bus.in_sel = 2'b00;
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (ov[k] !== 1'b0 || od[k] !== '0) begin
        failed++;
        $display("FAIL midreset_out%0d: valid=%b data=%h, want 0/0", k, ov[k], od[k]);
      end
    end
    tests++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      failed++;
      $display("FAIL midreset_status: busy=%b in_ready=%b, want 0/1", bus.busy, bus.in_ready);
    end
    #1;
    reset = 1'b0;
    push(2'b00, 28'h0ABCDEF);
    tests++;
    if (ov[0] !== 1'b1 || od[0] !== 28'h0ABCDEF || ov[1] !== 1'b0 || ov[2] !== 1'b0 || ov[3] !== 1'b0) begin
      failed++;
      $display("FAIL post_reset_push: out0 %b/%h others %b%b%b, want 1/0abcdef 000", ov[0], od[0], ov[1], ov[2], ov[3]);
    end
    $display("[TB] test_mid_reset done");
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b0;
    idle();
    test_reset();
    test_routing();
    test_fill_backpressure();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/demux4.md
# demux4

Four-way routing buffer, the inverse of the 28-bit `mux4` selector. It accepts one `WIDTH`-bit word per cycle on a valid/ready input port and steers it by a 2-bit destination code into one of four independent output channels. Each channel has its own `DEPTH`-entry FIFO and a valid/ready handshake. It sits between a shared producer and four consumers, so a stalled consumer only blocks words addressed to it.

## Interface
- `WIDTH`, 28, data word width
- `DEPTH`, 2, entries per channel FIFO; power of two, ≥ 2
- `clk`  in  1  rising-edge clock, the only clock
- `reset`  in  1  asynchronous, active-high; clears all state
- `in_valid`  in  1  producer has a word
- `in_ready`  out  1  word can be accepted this cycle
- `in_data`  in  WIDTH  word to route
- `in_sel`  in  2  destination channel: 00→0, 01→1, 10→2, 11→3; meaningful only while `in_valid`=1
- `outK_valid`  out  1  channel K (K=0..3) head entry is valid
- `outK_ready`  in  1  consumer K takes the head this cycle
- `outK_data`  out  WIDTH  channel K head word; 0 when `outK_valid`=0
- `busy`  out  1  at least one channel FIFO is non-empty

## Operation
- **Channel state.** Each channel has DEPTH storage entries, a write pointer, a read pointer and an occupancy count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- **Input ready.** `in_ready` = NOT full[`in_sel`].
  - Combinational from `in_sel` and registered occupancy only.
  - No path from any `outK_ready`.
- **Push.** A push occurs when `in_valid` and `in_ready` are both 1. It writes `in_data` at wrptr[`in_sel`] and increments that pointer and count.
- **Pop.** A pop on channel K occurs when `outK_valid` and `outK_ready` are both 1. It advances rdptr[K] and decrements count[K].
- **Simultaneous push and pop on one channel.** Count is unchanged and both pointers advance.
  - Allowed only when the channel is not full, since `in_ready` is already 0 when full.
  - A pop on a full channel frees the slot on the next cycle, not the same cycle.
- **Channel outputs.** `outK_valid` = (count[K] ≠ 0). `outK_data` = mem[K][rdptr[K]] when valid, else 0.
- **Ordering.** Per-channel FIFO order is preserved. There is no ordering relation between channels.
- **Status.** `busy` = OR of all four `outK_valid`.
- **Reset, asserted at any time, including mid-transfer.**
  - All counts, pointers and storage are cleared and in-flight words are discarded.
  - `outK_valid`=0, `outK_data`=0, `busy`=0.
  - `in_ready`=1, because all channels are empty.
- **Illegal inputs.** X or changing `in_sel` while `in_valid`=0 must not affect state.

## Timing
- **Latency.** 1 cycle. A word pushed at edge N is visible as `outK_valid`=1 with its data after edge N. It can be popped at edge N+1 at the earliest.
- **Throughput.** One word per cycle into any non-full channel. Each channel drains one word per cycle.
- **Backpressure.** When channel K is full, `in_ready` drops combinationally whenever `in_sel`=K. The producer must hold `in_data` and `in_sel` stable until accepted.
- **Pop visibility.** A pop at edge N makes the next entry, or 0 if the channel is now empty, visible after edge N.
- **Reset.** Assertion clears outputs immediately, without waiting for `clk`. Deassertion is synchronized externally. The first push may occur at the first edge after deassertion.

## Test plan
- **Routing.** With all `outK_ready`=0, push 0x0000555 sel=01, 0x00FFFFF sel=00, 0xCCCCC sel=11, 0x0000810 sel=10.
  - Expect `out0_data`=0xFFFFF, `out1_data`=0x555, `out2_data`=0x810, `out3_data`=0xCCCCC.
  - Expect all four valids=1 and `busy`=1.
- **Fill and backpressure.** With `out2_ready`=0 and DEPTH=2, push 0x1 then 0x2 to channel 2.
  - Third attempt with sel=10 sees `in_ready`=0.
  - Switching sel to 00 in the same cycle gives `in_ready`=1, and that word lands in channel 0.
- **Drain order.** Release `out2_ready`=1. Expect `out2_data` 0x1, then 0x2 on consecutive cycles, then `out2_valid`=0 and `out2_data`=0.
- **Simultaneous push and pop.** Channel 1 holds one word, 0xA. Push 0xB with sel=01 while `out1_ready`=1.
  - Count stays 1 and `out1_data` becomes 0xB next cycle.
  - Streaming 0xC, 0xD, … each cycle with `out1_ready`=1 sustains one word per cycle with no bubble.
- **Wrap-around.** Stream 10 words 0x10..0x19 through channel 3 with randomized `out3_ready`. Expect exact in-order output across pointer wrap and no loss or duplication.
- **Mid-operation reset.** Fill all channels, then pulse `reset` asynchronously between edges.
  - Expect immediately: all valids=0, all data=0, `busy`=0, `in_ready`=1.
  - Expect the first post-reset push, 0x0ABCDEF sel=00, to appear alone on `out0`.
